// File: rtl/add_multi.sv
// add_multi: multi-channel signed accumulator with per-sample channel select.
// Saturating arithmetic when ADD_MULTI_SAT_EN is defined, otherwise wraps.
module add_multi #(
    parameter int DW  = 16,
    parameter int AW  = 20,
    parameter int NCH = 4,
    parameter int CW  = 8,
    localparam int CHW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic signed [DW-1:0] i_data,
    input  logic [CHW-1:0]       i_ch,
    input  logic                 i_val,
    input  logic                 i_init,
    input  logic                 i_last,
    output logic [AW-1:0]        o_data,
    output logic [CHW-1:0]       o_ch,
    output logic [CW-1:0]        o_cnt,
    output logic                 o_val,
    output logic                 o_ovf,
    output logic                 o_err,
    output logic [NCH-1:0]       o_active
);

    localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

    logic signed [AW-1:0] acc   [NCH];
    logic signed [AW-1:0] acc_n [NCH];
    logic [CW-1:0]        cnt   [NCH];
    logic [CW-1:0]        cnt_n [NCH];
    logic [NCH-1:0]       active;
    logic [NCH-1:0]       active_n;

    logic                 in_rng;
    logic                 hit;
    logic                 fresh;
    logic [CHW-1:0]       sel;
    logic signed [AW-1:0] base_acc;
    logic [CW-1:0]        base_cnt;
    logic [CW-1:0]        cnt_nx;
    logic signed [AW-1:0] res;

`ifdef ADD_MULTI_SAT_EN
    localparam logic signed [AW-1:0] MAX_V = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {1'b1, {(AW-1){1'b0}}};

    logic [NCH-1:0]       ovf;
    logic [NCH-1:0]       ovf_n;
    logic signed [AW:0]   sum;
    logic                 ovf_now;
    logic                 ovf_nx;
`else
    logic signed [AW-1:0] sum;
`endif

    // Sum and count for the selected channel; an idle channel starts from zero
    always_comb begin
        in_rng   = ({1'b0, i_ch} < NCH_L);
        hit      = i_val & in_rng;
        sel      = in_rng ? i_ch : '0;
        fresh    = i_init | ~active[sel];
        base_acc = fresh ? '0 : acc[sel];
        base_cnt = fresh ? '0 : cnt[sel];
        cnt_nx   = (&base_cnt) ? base_cnt : base_cnt + 1'b1;
`ifdef ADD_MULTI_SAT_EN
        sum      = {base_acc[AW-1], base_acc} + (AW+1)'(i_data);
        ovf_now  = sum[AW] ^ sum[AW-1];
        ovf_nx   = ovf_now | (~fresh & ovf[sel]);
        if (ovf_now)
            res = sum[AW] ? MIN_V : MAX_V;
        else
            res = sum[AW-1:0];
`else
        sum      = base_acc + AW'(i_data);
        res      = sum;
`endif
    end

    // Next per-channel state: open/extend on a plain sample, clear on the last one
    always_comb begin
        acc_n    = acc;
        cnt_n    = cnt;
        active_n = active;
`ifdef ADD_MULTI_SAT_EN
        ovf_n    = ovf;
`endif
        if (hit) begin
            if (i_last) begin
                acc_n[sel]    = '0;
                cnt_n[sel]    = '0;
                active_n[sel] = 1'b0;
`ifdef ADD_MULTI_SAT_EN
                ovf_n[sel]    = 1'b0;
`endif
            end else begin
                acc_n[sel]    = res;
                cnt_n[sel]    = cnt_nx;
                active_n[sel] = 1'b1;
`ifdef ADD_MULTI_SAT_EN
                ovf_n[sel]    = ovf_nx;
`endif
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int k = 0; k < NCH; k++) begin
                acc[k] <= '0;
                cnt[k] <= '0;
            end
            active <= '0;
`ifdef ADD_MULTI_SAT_EN
            ovf    <= '0;
`endif
        end else begin
            acc    <= acc_n;
            cnt    <= cnt_n;
            active <= active_n;
`ifdef ADD_MULTI_SAT_EN
            ovf    <= ovf_n;
`endif
        end
    end

    // Result registers: strobes pulse, payload holds until the next result
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            o_val  <= 1'b0;
            o_err  <= 1'b0;
            o_data <= '0;
            o_ch   <= '0;
            o_cnt  <= '0;
`ifdef ADD_MULTI_SAT_EN
            o_ovf  <= 1'b0;
`endif
        end else begin
            o_val <= hit & i_last;
            o_err <= i_val & ~in_rng;
            if (hit && i_last) begin
                o_data <= res;
                o_ch   <= i_ch;
                o_cnt  <= cnt_nx;
`ifdef ADD_MULTI_SAT_EN
                o_ovf  <= ovf_nx;
`endif
            end
        end
    end

`ifndef ADD_MULTI_SAT_EN
    assign o_ovf = 1'b0;
`endif

    assign o_active = active;

endmodule

// File: tb/tb_add_multi.sv
// tb_add_multi: scoreboard bench for add_multi (NCH=4 main instance, NCH=3
// instance for the out-of-range channel case).
module tb_add_multi;

    typedef struct {
        logic [19:0] data;
        logic [1:0]  ch;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic xrst = 1'b0;

    logic signed [15:0] i_data = '0;
    logic [1:0]  i_ch = '0;
    logic i_val = 1'b0, i_init = 1'b0, i_last = 1'b0;
    logic [19:0] o_data;
    logic [1:0]  o_ch;
    logic [7:0]  o_cnt;
    logic o_val, o_ovf, o_err;
    logic [3:0]  o_active;

    logic signed [15:0] d3 = '0;
    logic [1:0]  c3 = '0;
    logic v3 = 1'b0, n3 = 1'b0, l3 = 1'b0;
    logic [19:0] o_data3;
    logic [1:0]  o_ch3;
    logic [7:0]  o_cnt3;
    logic o_val3, o_ovf3, o_err3;
    logic [2:0]  o_active3;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total = 0;

    always #5 clk = ~clk;

    add_multi #(.DW(16), .AW(20), .NCH(4), .CW(8)) dut (
        .clk(clk), .xrst(xrst), .i_data(i_data), .i_ch(i_ch),
        .i_val(i_val), .i_init(i_init), .i_last(i_last),
        .o_data(o_data), .o_ch(o_ch), .o_cnt(o_cnt), .o_val(o_val),
        .o_ovf(o_ovf), .o_err(o_err), .o_active(o_active)
    );

    add_multi #(.DW(16), .AW(20), .NCH(3), .CW(8)) dut3 (
        .clk(clk), .xrst(xrst), .i_data(d3), .i_ch(c3),
        .i_val(v3), .i_init(n3), .i_last(l3),
        .o_data(o_data3), .o_ch(o_ch3), .o_cnt(o_cnt3), .o_val(o_val3),
        .o_ovf(o_ovf3), .o_err(o_err3), .o_active(o_active3)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    task automatic send(input int ch, input int d, input bit ini, input bit lst);
        @(negedge clk);
        i_val  = 1'b1;
        i_ch   = 2'(ch);
        i_data = 16'(d);
        i_init = ini;
        i_last = lst;
    endtask

    task automatic idle();
        @(negedge clk);
        i_val  = 1'b0;
        i_init = 1'b0;
        i_last = 1'b0;
        v3 = 1'b0;
        n3 = 1'b0;
        l3 = 1'b0;
    endtask

    task automatic push(input int d, input int ch, input int c, input bit ov);
        exp_t e;
        e.data = 20'(d);
        e.ch   = 2'(ch);
        e.cnt  = 8'(c);
        e.ovf  = ov;
        sb.push_back(e);
    endtask

    // Monitor: every result strobe must match the oldest expected entry
    always @(negedge clk) begin
        if (xrst && o_val) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_oval: got data %0d ch %0d expected none",
                         $signed(o_data), o_ch);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("o_data", 32'($signed(o_data)), 32'($signed(e.data)));
                chk("o_ch",   32'(o_ch),  32'(e.ch));
                chk("o_cnt",  32'(o_cnt), 32'(e.cnt));
                chk("o_ovf",  32'(o_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_oval",   32'(o_val),    0);
        chk("rst_odata",  32'(o_data),   0);
        chk("rst_active", 32'(o_active), 0);
        chk("rst_oerr",   32'(o_err),    0);
        #20 xrst = 1'b1;

        // single channel: 5 - 3 + 10
        send(0, 5, 1, 0);
        send(0, -3, 0, 0);
        chk("act_open", 32'(o_active), 32'h1);
        send(0, 10, 0, 1);
        push(12, 0, 3, 0);
        idle();
        chk("act_close", 32'(o_active), 0);
        idle();

        // interleaved channels 1 and 2
        send(1, 100, 1, 0);
        send(2, -7, 1, 0);
        send(1, 20, 0, 0);
        chk("act_12", 32'(o_active), 32'h6);
        send(2, -1, 0, 1);
        push(-8, 2, 2, 0);
        send(1, 1, 0, 1);
        push(121, 1, 3, 0);
        idle();
        chk("act_none", 32'(o_active), 0);

        // restart on init, then single-term sum
        send(3, 50, 1, 0);
        send(3, 4, 1, 0);
        send(3, 6, 0, 1);
        push(10, 3, 2, 0);
        send(2, -32768, 1, 1);
        push(-32768, 2, 1, 0);
        idle();

        // 33 terms of 32767 = 1081311, beyond 20-bit range
        send(0, 32767, 1, 0);
        repeat (31) send(0, 32767, 0, 0);
        send(0, 32767, 0, 1);
`ifdef ADD_MULTI_SAT_EN
        push(524287, 0, 33, 1);
`else
        push(32735, 0, 33, 0);
`endif
        idle();
        idle();

        // asynchronous reset in the middle of an open sum
        send(0, 9, 1, 0);
        idle();
        chk("act_pre_rst", 32'(o_active), 32'h1);
        #2 xrst = 1'b0;
        #1;
        chk("arst_active", 32'(o_active), 0);
        chk("arst_odata",  32'(o_data),   0);
        chk("arst_ocnt",   32'(o_cnt),    0);
        chk("arst_oval",   32'(o_val),    0);
        @(negedge clk);
        xrst = 1'b1;
        send(0, 1, 0, 1);
        push(1, 0, 1, 0);
        idle();

        // out-of-range channel on the 3-channel instance
        @(negedge clk);
        v3 = 1'b1; c3 = 2'd1; d3 = 16'sd7; n3 = 1'b1; l3 = 1'b0;
        @(negedge clk);
        c3 = 2'd3; d3 = 16'sd99; n3 = 1'b1; l3 = 1'b1;
        chk("n3_act_open", 32'(o_active3), 32'h2);
        idle();
        chk("n3_err",     32'(o_err3),    1);
        chk("n3_oval",    32'(o_val3),    0);
        chk("n3_act_kept", 32'(o_active3), 32'h2);
        @(negedge clk);
        chk("n3_err_pulse", 32'(o_err3), 0);
        v3 = 1'b1; c3 = 2'd1; d3 = 16'sd3; n3 = 1'b0; l3 = 1'b1;
        idle();
        chk("n3_oval_last", 32'(o_val3), 1);
        chk("n3_odata",     32'($signed(o_data3)), 32'd10);
        chk("n3_ocnt",      32'(o_cnt3), 32'd2);

        idle();
        idle();
        chk("sb_drain", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
